// File: rtl/ar_id_scheduler.sv
// rtl/ar_id_scheduler.sv - round-robin AR scheduler with per-ID outstanding-read limits
//
// Ports:
//   Aclk, ARESETRst      clock, asynchronous active-high reset
//   req_valid/req_addr   per-requester read request and 32-bit address (slice i = requester i)
//   req_ready            one-cycle acceptance pulse on the downstream AR handshake
//   m_AR_*               downstream AR channel (ID = granted requester index)
//   R_valid/R_Ready/     monitored R channel; a last beat retires one outstanding read
//   R_last/R_ID          for the requester in the low ID_WIDTH bits of R_ID
//   busy                 any outstanding counter nonzero
//   err_underflow        sticky: completion seen for an ID with nothing outstanding
module ar_id_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2,
  parameter int ID_PAD    = 4,
  parameter int MAX_OUTST = 8
) (
  input  logic                         Aclk,
  input  logic                         ARESETRst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*32-1:0]        req_addr,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         m_AR_valid,
  input  logic                         m_AR_Ready,
  output logic [ID_WIDTH-1:0]          m_AR_ID,
  output logic [31:0]                  m_AR_addr,
  input  logic                         R_valid,
  input  logic                         R_Ready,
  input  logic                         R_last,
  input  logic [ID_WIDTH+ID_PAD-1:0]   R_ID,
  output logic                         busy,
  output logic                         err_underflow
);

  localparam int            CW    = $clog2(MAX_OUTST + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_OUTST);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] last_q, last_d;
  logic [31:0]         addr_q, addr_d;
  logic [CW-1:0]       cnt_q [NUM_REQ];
  logic [CW-1:0]       cnt_d [NUM_REQ];
  logic                err_q, err_d;

  logic [31:0]         addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic [NUM_REQ-1:0]  inc_v, dec_v;
  logic                ar_fire, r_fire;
  logic [ID_WIDTH-1:0] r_idx;
  logic [ID_WIDTH-1:0] idx;
  logic                found;

  // Upper R_ID bits carry the sequence field, which this block does not track.
  logic unused_rid;
  assign unused_rid = ^R_ID[ID_WIDTH+ID_PAD-1:ID_WIDTH];

  assign ar_fire = (state_q == SEND) && m_AR_Ready;
  assign r_fire  = R_valid && R_Ready && R_last;
  assign r_idx   = R_ID[ID_WIDTH-1:0];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign addr_arr[g] = req_addr[g*32 +: 32];
    assign eligible[g] = req_valid[g] && (cnt_q[g] < MAX_C);
    assign inc_v[g]    = ar_fire && (grant_q == ID_WIDTH'(g));
    assign dec_v[g]    = r_fire && (r_idx == ID_WIDTH'(g));
  end

  // Arbitration and AR channel control.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    last_d  = last_q;
    found   = 1'b0;
    idx     = '0;
    case (state_q)
      IDLE: begin
        // Search last+1, last+2, ... wrapping; offset NUM_REQ lands back on last.
        for (int k = 1; k <= NUM_REQ; k++) begin
          idx = last_q + ID_WIDTH'(k);
          if (!found && eligible[idx]) begin
            found   = 1'b1;
            grant_d = idx;
            addr_d  = addr_arr[idx];
          end
        end
        if (found) state_d = SEND;
      end
      SEND: begin
        if (m_AR_Ready) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outstanding counters; a same-cycle issue and retire on one ID cancel out.
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_v[i] && !dec_v[i]) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (dec_v[i] && !inc_v[i]) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge Aclk or posedge ARESETRst) begin
    if (ARESETRst) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      last_q  <= ID_WIDTH'(NUM_REQ - 1);
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      err_q   <= err_d;
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) busy = busy | (cnt_q[i] != '0);
  end

  assign req_ready     = inc_v;
  assign m_AR_valid    = (state_q == SEND);
  assign m_AR_ID       = grant_q;
  assign m_AR_addr     = addr_q;
  assign err_underflow = err_q;

endmodule
